// File: rtl/exp_decay_pkg.sv
// rtl/exp_decay_pkg.sv - shared constants and state encoding for the exponential decay analyzer
package exp_decay_pkg;

  localparam int FRAC_BITS = 14;
  localparam int INV_E_Q14 = 6027;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISE    = 2'd1,
    DECAY   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/exp_sample_clamp.sv
// rtl/exp_sample_clamp.sv - signed sample to unsigned magnitude: negatives to 0, overrange saturated
module exp_sample_clamp #(
  parameter int DATA_WIDTH = 16,
  parameter int DAC_WIDTH  = 14
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic        [DAC_WIDTH-1:0]  mag
);

  localparam logic [DATA_WIDTH-1:0] MAX_MAG = DATA_WIDTH'((1 << DAC_WIDTH) - 1);

  always_comb begin
    mag = '1;
    if (sample[DATA_WIDTH-1]) begin
      mag = '0;
    end else if ($unsigned(sample) <= MAX_MAG) begin
      mag = sample[DAC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/exp_decay_analyzer.sv
// rtl/exp_decay_analyzer.sv - pulse peak and decay-to-1/e time analyzer; EXP_DECAY_ANALYZER_STATS_EN adds result counters
module exp_decay_analyzer
  import exp_decay_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DAC_WIDTH  = 14,
  parameter int CNT_WIDTH  = 20,
  parameter int RATIO_Q14  = INV_E_Q14
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic        [DAC_WIDTH-1:0]  threshold,
  output logic        [DAC_WIDTH-1:0]  peak_out,
  output logic        [CNT_WIDTH-1:0]  decay_cnt,
  output logic                         result_valid,
  output logic                         timeout,
  output logic                         busy
`ifdef EXP_DECAY_ANALYZER_STATS_EN
  ,
  output logic        [15:0]           pulse_count,
  output logic        [15:0]           timeout_count
`endif
);

  localparam int PROD_WIDTH = DAC_WIDTH + FRAC_BITS;

  state_t                 state;
  logic [DAC_WIDTH-1:0]   mag;
  logic [DAC_WIDTH-1:0]   peak;
  logic [DAC_WIDTH-1:0]   thr_q;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   count_inc;
  logic [PROD_WIDTH-1:0]  product;
  logic [DAC_WIDTH-1:0]   target;
  logic                   fin_pend;
  logic                   fin_to;

  exp_sample_clamp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DAC_WIDTH (DAC_WIDTH)
  ) u_clamp (
    .sample(s_axis_tdata),
    .mag   (mag)
  );

  assign product   = PROD_WIDTH'(peak) * PROD_WIDTH'(RATIO_Q14);
  assign target    = product[PROD_WIDTH-1:FRAC_BITS];
  assign count_inc = count + 1'b1;
  assign busy      = (state != IDLE);

  // The ending sample only arms fin_pend; outputs publish on the following edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      peak         <= '0;
      thr_q        <= '0;
      count        <= '0;
      fin_pend     <= 1'b0;
      fin_to       <= 1'b0;
      peak_out     <= '0;
      decay_cnt    <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= fin_pend;
      fin_pend     <= 1'b0;
      if (fin_pend) begin
        peak_out  <= peak;
        decay_cnt <= count;
        timeout   <= fin_to;
      end
      if (s_axis_tvalid) begin
        case (state)
          IDLE: begin
            if (threshold != '0 && mag >= threshold) begin
              thr_q <= threshold;
              peak  <= mag;
              state <= RISE;
            end
          end
          RISE: begin
            if (mag > peak) begin
              peak <= mag;
            end else if (mag < peak) begin
              count <= CNT_WIDTH'(1);
              if (mag <= target) begin
                fin_pend <= 1'b1;
                fin_to   <= 1'b0;
                state    <= HOLDOFF;
              end else begin
                state <= DECAY;
              end
            end
          end
          DECAY: begin
            count <= count_inc;
            if (mag <= target) begin
              fin_pend <= 1'b1;
              fin_to   <= 1'b0;
              state    <= HOLDOFF;
            end else if (count_inc == {CNT_WIDTH{1'b1}}) begin
              fin_pend <= 1'b1;
              fin_to   <= 1'b1;
              state    <= HOLDOFF;
            end
          end
          HOLDOFF: begin
            if (mag < thr_q) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef EXP_DECAY_ANALYZER_STATS_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pulse_count   <= '0;
      timeout_count <= '0;
    end else if (fin_pend) begin
      if (pulse_count != 16'hFFFF) begin
        pulse_count <= pulse_count + 16'd1;
      end
      if (fin_to && timeout_count != 16'hFFFF) begin
        timeout_count <= timeout_count + 16'd1;
      end
    end
  end
`endif

endmodule
